// File: rtl/bcd_display_scan_if.sv
// Bus between a BCD producer and the multiplexed seven-segment scanner.
// The producer drives the digit word and display controls; the scanner drives the display pins.
interface bcd_display_scan_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  bcd_valid;
  logic                  blank_lz;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output bcd_in, bcd_valid, blank_lz, dp_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  bcd_in, bcd_valid, blank_lz, dp_mask,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned updates,
// leading-zero blanking and per-digit decimal points. All display pins are registered.
module bcd_display_scan #(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  bcd_display_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIGIT0_EN  = N_DIGITS'(1);

  // Segment patterns, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       shadow;
  logic [DW-1:0]       display;
  logic                pending;
  logic                wrap_q;

  logic                presc_last;
  logic                wrap;
  logic [3:0]          cur_digit;
  logic [N_DIGITS-1:0] nz_tail;
  logic                nz_acc;
  logic                blanked;
  logic [N_DIGITS-1:0] an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  assign presc_last = (presc == PRESC_LAST);
  assign wrap       = presc_last && (idx == IDX_LAST);

  // nz_tail[i] is set when any display digit from i upward is non-zero.
  // NOTE: every variable gets a default before the loop so no path can infer a latch.
  always_comb begin
    nz_tail = '0;
    nz_acc  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nz_acc     = nz_acc | (|display[4*i +: 4]);
      nz_tail[i] = nz_acc;
    end
  end

  always_comb begin
    cur_digit = display[4*idx +: 4];
    blanked   = bus.blank_lz && (idx != '0) && !nz_tail[idx];
    an_nx     = ~(DIGIT0_EN << idx);
    seg_nx    = seg_decode(cur_digit);
    dp_nx     = ~bus.dp_mask[idx];
    if (blanked) begin
      an_nx  = '1;
      seg_nx = SEG_OFF;
      dp_nx  = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc          <= '0;
      idx            <= '0;
      shadow         <= '0;
      display        <= '0;
      pending        <= 1'b0;
      wrap_q         <= 1'b0;
      bus.an         <= '1;
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      presc <= presc_last ? '0 : presc + PW'(1);
      if (presc_last) idx <= wrap ? '0 : idx + IW'(1);

      if (bus.bcd_valid) shadow <= bus.bcd_in;

      if (wrap)               pending <= 1'b0;
      else if (bus.bcd_valid) pending <= 1'b1;

      // A strobe landing on the wrap cycle itself is newer than the shadow.
      if (wrap && bus.bcd_valid) display <= bus.bcd_in;
      else if (wrap && pending)  display <= shadow;

      // Outputs lag idx by one cycle, so frame_done trails the wrap by one too.
      wrap_q         <= wrap;
      bus.frame_done <= wrap_q;
      bus.an         <= an_nx;
      bus.seg        <= seg_nx;
      bus.dp         <= dp_nx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: N_DIGITS=8, SCAN_DIV=4, whole frames compared
// cycle by cycle against hand-tabulated segment codes.
module tb_bcd_display_scan;

  localparam int N     = 8;
  localparam int SD    = 4;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_display_scan_if #(.N_DIGITS(N)) bus ();

  bcd_display_scan #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] seg_tbl [16];

  localparam logic [31:0] RESET_OUT = {15'd0, 1'b0, 8'hFF, 7'h7F, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return {15'd0, bus.frame_done, bus.an, bus.seg, bus.dp};
  endfunction

  // Expected {frame_done, an, seg, dp} for one digit slot
  function automatic logic [31:0] expect_out(input logic [31:0] disp, input logic blank,
                                             input logic [7:0] dpm, input int slot,
                                             input logic fd);
    logic [3:0]  d;
    logic        blk;
    logic [7:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic [31:0] tail;
    d     = disp[4*slot +: 4];
    tail  = disp >> (4 * slot);
    blk   = blank && (slot > 0) && (tail == 32'd0);
    an_e  = blk ? 8'hFF : ~(8'h01 << slot);
    seg_e = blk ? 7'h7F : seg_tbl[d];
    dp_e  = blk ? 1'b1 : ~dpm[slot];
    return {15'd0, fd, an_e, seg_e, dp_e};
  endfunction

  // Checks one frame; optional strobes are driven during the given cycles, and
  // abort_cyc raises rst after that cycle's comparison.
  task automatic run_frame(input string name, input logic [31:0] disp, input bit first,
                           input logic blank, input logic [7:0] dpm,
                           input int s0c, input logic [31:0] s0v,
                           input int s1c, input logic [31:0] s1v,
                           input int s2c, input logic [31:0] s2v,
                           input int abort_cyc);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), observed(),
            expect_out(disp, blank, dpm, c / SD, (c == 0) && !first));
      bus.bcd_valid = 1'b0;
      if (c == s0c) begin bus.bcd_valid = 1'b1; bus.bcd_in = s0v; end
      if (c == s1c) begin bus.bcd_valid = 1'b1; bus.bcd_in = s1v; end
      if (c == s2c) begin bus.bcd_valid = 1'b1; bus.bcd_in = s2v; end
      if (c == abort_cyc) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0111111;

    rst           = 1'b1;
    bus.bcd_in    = '0;
    bus.bcd_valid = 1'b0;
    bus.blank_lz  = 1'b0;
    bus.dp_mask   = '0;
    repeat (3) @(negedge clk);
    check("reset", observed(), RESET_OUT);
    rst = 1'b0;

    // Blank display after reset; a mid-frame strobe must not disturb this frame
    run_frame("A", 32'h0, 1'b1, 1'b0, 8'h00, 10, 32'h00012345, -1, 0, -1, 0, -1);
    run_frame("B", 32'h00012345, 1'b0, 1'b0, 8'h00, -1, 0, -1, 0, -1, 0, -1);

    bus.blank_lz = 1'b1;
    run_frame("C", 32'h00012345, 1'b0, 1'b1, 8'h00, 5, 32'h0, -1, 0, -1, 0, -1);
    // All-zero with blanking; last strobe lands exactly on the wrap cycle
    run_frame("D", 32'h0, 1'b0, 1'b1, 8'h00,
              3, 32'h11111111, 12, 32'h22222222, FRAME - 2, 32'h33333333, -1);

    bus.blank_lz = 1'b0;
    run_frame("E", 32'h33333333, 1'b0, 1'b0, 8'h00, 20, 32'h00000A00, -1, 0, -1, 0, -1);

    // Dash plus decimal point in slot 2, then reset in slot 5 with an update pending
    bus.dp_mask = 8'h04;
    run_frame("F", 32'h00000A00, 1'b0, 1'b0, 8'h04, 8, 32'h99999999, -1, 0, -1, 0, 21);
    @(negedge clk);
    check("reset mid-frame", observed(), RESET_OUT);
    rst = 1'b0;

    run_frame("G", 32'h0, 1'b1, 1'b0, 8'h04, -1, 0, -1, 0, -1, 0, -1);
    run_frame("H", 32'h0, 1'b0, 1'b0, 8'h04, -1, 0, -1, 0, -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
